// File: rtl/dtt_xbar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dtt_xbar_pkg
//  Description : Shared constants, types and helpers for the buffered DTT
//                crossbar: drop-counter width, a clog2 helper usable in port
//                declarations, and the round-robin priority pick used by
//                every output arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dtt_xbar_pkg;

    localparam int DROP_W    = 16;
    // The arbiter helper works on a fixed-width request vector, so the
    // crossbar supports at most MAX_PORTS inputs.
    localparam int MAX_PORTS = 32;
    localparam int RR_IDX_W  = 5;

    typedef struct packed {
        logic                valid;
        logic [RR_IDX_W-1:0] idx;
    } rr_grant_t;

    // Ceiling log2. Evaluated at elaboration only.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) begin
                result = b + 1;
            end
        end
        return result;
    endfunction

    // Round-robin pick: first set bit of req[n-1:0] scanning upward from
    // ptr+1, wrapping modulo n. ptr is the most recently granted index.
    function automatic rr_grant_t rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [RR_IDX_W-1:0]  ptr,
        input int unsigned          n
    );
        rr_grant_t   g;
        int unsigned cand;
        g = '0;
        for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
            // ptr < n and k <= n, so one subtraction is a full modulo.
            cand = 32'(ptr) + k;
            if (cand >= n) begin
                cand = cand - n;
            end
            if (k <= n && !g.valid && req[cand[RR_IDX_W-1:0]]) begin
                g.valid = 1'b1;
                g.idx   = cand[RR_IDX_W-1:0];
            end
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtt_xbar_in_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dtt_xbar_in_fifo
//  Description : Per-input synchronous FIFO of the buffered DTT crossbar.
//                The head entry is readable combinationally. A push into a
//                full FIFO is refused even when a pop happens the same cycle.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                push_i/data_i - write strobe and entry
//                pop_i         - discard head entry
//                head_o        - current head entry (valid when !empty_o)
//                full_o/empty_o/count_o - occupancy from the registered count
//  Revision    : 1.0 - initial release
// ============================================================================
module dtt_xbar_in_fifo
    import dtt_xbar_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        data_i,
    output logic [WIDTH-1:0]        head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are log2(DEPTH) bits wide and wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dtt_crossbar_rr_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : dtt_crossbar_rr_buffered
//  Description : Buffered N_IN x N_OUT crossbar. Each input feeds a FIFO;
//                each FIFO head requests the output named by its destination
//                index; one round-robin arbiter per output picks a winner
//                which is loaded into that output's register. Heads with an
//                out-of-range destination are dropped and counted.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                in_data_i/in_dest_i/in_valid_i/in_ready_o - per-input stream,
//                                    packed port-major (port k at slice k)
//                out_data_o/out_src_o/out_valid_o/out_ready_i - per-output
//                                    stream, out_src_o is the input index
//                drop_cnt_o        - saturating count of dropped words
//  Revision    : 1.0 - initial release
// ============================================================================
module dtt_crossbar_rr_buffered
    import dtt_xbar_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_IN*DATA_WIDTH-1:0]      in_data_i,
    input  logic [N_IN*clog2(N_OUT)-1:0]    in_dest_i,
    input  logic [N_IN-1:0]                 in_valid_i,
    output logic [N_IN-1:0]                 in_ready_o,
    output logic [N_OUT*DATA_WIDTH-1:0]     out_data_o,
    output logic [N_OUT*clog2(N_IN)-1:0]    out_src_o,
    output logic [N_OUT-1:0]                out_valid_o,
    input  logic [N_OUT-1:0]                out_ready_i,
    output logic [DROP_W-1:0]               drop_cnt_o
);

    localparam int DEST_W  = clog2(N_OUT);
    localparam int SRC_W   = clog2(N_IN);
    localparam int ENTRY_W = DATA_WIDTH + DEST_W;
    localparam int BAD_W   = SRC_W + 1;

    logic [ENTRY_W-1:0]    head_entry [N_IN];
    logic [DATA_WIDTH-1:0] head_data  [N_IN];
    logic [DEST_W-1:0]     head_dest  [N_IN];
    logic [N_IN-1:0]       fifo_full;
    logic [N_IN-1:0]       fifo_empty;
    logic [N_IN-1:0]       fifo_pop;
    logic [N_IN-1:0]       head_ok;
    logic [N_IN-1:0]       head_bad;
    logic [N_IN-1:0]       req        [N_OUT];
    rr_grant_t             gnt        [N_OUT];
    logic [SRC_W-1:0]      gnt_idx    [N_OUT];
    logic [N_OUT-1:0]      gnt_fire;
    logic [N_OUT-1:0]      can_load;
    logic [SRC_W:0]        cnt_unused [N_IN];

    logic [DATA_WIDTH-1:0] out_data_q [N_OUT];
    logic [DATA_WIDTH-1:0] out_data_d [N_OUT];
    logic [SRC_W-1:0]      out_src_q  [N_OUT];
    logic [SRC_W-1:0]      out_src_d  [N_OUT];
    logic [SRC_W-1:0]      rr_ptr_q   [N_OUT];
    logic [SRC_W-1:0]      rr_ptr_d   [N_OUT];
    logic [N_OUT-1:0]      out_valid_q;
    logic [N_OUT-1:0]      out_valid_d;
    logic [DROP_W-1:0]     drop_cnt_q;
    logic [DROP_W-1:0]     drop_cnt_d;
    logic [DROP_W:0]       drop_sum;
    logic [BAD_W-1:0]      n_bad;

    // Held low during reset so no source believes a word was taken.
    assign in_ready_o = ~fifo_full & {N_IN{~rst}};

    for (genvar i = 0; i < N_IN; i++) begin : g_fifo
        dtt_xbar_in_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (in_valid_i[i] && in_ready_o[i]),
            .pop_i   (fifo_pop[i]),
            .data_i  ({in_dest_i[i*DEST_W +: DEST_W],
                       in_data_i[i*DATA_WIDTH +: DATA_WIDTH]}),
            .head_o  (head_entry[i]),
            .full_o  (fifo_full[i]),
            .empty_o (fifo_empty[i]),
            .count_o (cnt_unused[i])
        );
        assign {head_dest[i], head_data[i]} = head_entry[i];
    end

    // Request matrix: a head requests exactly one output, so an input can
    // never be granted by two arbiters in the same cycle.
    always_comb begin
        head_ok  = '0;
        head_bad = '0;
        for (int i = 0; i < N_IN; i++) begin
            head_ok[i]  = !fifo_empty[i] && (int'(head_dest[i]) <  N_OUT);
            head_bad[i] = !fifo_empty[i] && (int'(head_dest[i]) >= N_OUT);
        end
        for (int j = 0; j < N_OUT; j++) begin
            req[j] = '0;
            for (int i = 0; i < N_IN; i++) begin
                req[j][i] = head_ok[i] && (int'(head_dest[i]) == j);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            gnt[j] = rr_pick(MAX_PORTS'(req[j]), RR_IDX_W'(rr_ptr_q[j]), N_IN);
        end
    end

    always_comb begin
        can_load = '0;
        gnt_fire = '0;
        for (int j = 0; j < N_OUT; j++) begin
            can_load[j] = !out_valid_q[j] || out_ready_i[j];
            gnt_fire[j] = can_load[j] && gnt[j].valid;
            gnt_idx[j]  = SRC_W'(gnt[j].idx);
        end
    end

    // Bad-destination heads leave unconditionally; granted heads leave
    // when their output register takes them.
    always_comb begin
        fifo_pop = head_bad;
        for (int j = 0; j < N_OUT; j++) begin
            if (gnt_fire[j]) begin
                fifo_pop[gnt_idx[j]] = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        for (int j = 0; j < N_OUT; j++) begin
            out_data_d[j] = out_data_q[j];
            out_src_d[j]  = out_src_q[j];
            rr_ptr_d[j]   = rr_ptr_q[j];
            if (can_load[j]) begin
                if (gnt_fire[j]) begin
                    out_data_d[j]  = head_data[gnt_idx[j]];
                    out_src_d[j]   = gnt_idx[j];
                    out_valid_d[j] = 1'b1;
                    rr_ptr_d[j]    = gnt_idx[j];
                end else begin
                    out_valid_d[j] = 1'b0;
                end
            end
        end

        n_bad = '0;
        for (int i = 0; i < N_IN; i++) begin
            n_bad = n_bad + BAD_W'(head_bad[i]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + (DROP_W + 1)'(n_bad);
        drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            drop_cnt_q  <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                out_data_q[j] <= '0;
                out_src_q[j]  <= '0;
                // Pointing at the last input gives input 0 first priority.
                rr_ptr_q[j]   <= SRC_W'(N_IN - 1);
            end
        end else begin
            out_valid_q <= out_valid_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int j = 0; j < N_OUT; j++) begin
                out_data_q[j] <= out_data_d[j];
                out_src_q[j]  <= out_src_d[j];
                rr_ptr_q[j]   <= rr_ptr_d[j];
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign out_data_o[j*DATA_WIDTH +: DATA_WIDTH] = out_data_q[j];
        assign out_src_o[j*SRC_W +: SRC_W]            = out_src_q[j];
    end
    assign out_valid_o = out_valid_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule
`default_nettype wire
